// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//
// Purpose:
//   Turns single-cycle event pulses into visible level windows. Each accepted
//   pulse produces one high window of HIGH_CYCLES clocks. After the window,
//   the output is held low for GAP_CYCLES clocks. Pulses that arrive while a
//   window or gap is in progress are queued in a saturating pending counter,
//   so no events are merged. When the queue is full, further pulses are
//   dropped and a sticky overflow flag is raised.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   pulseIn   in   event pulse; every edge sampled high counts as one event
//   clrOvf    in   synchronous clear of the overflow flag
//   levelOut  out  stretched level (registered)
//   busy      out  high whenever a window or gap is in progress (registered)
//   pending   out  queued pulses not yet displayed (registered)
//   overflow  out  sticky flag, set when a pulse was dropped (registered)

module pulse_stretcher #(
    parameter int HIGH_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulseIn,
    input  logic              clrOvf,
    output logic              levelOut,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0]        HIGH_LOAD = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0]        GAP_LOAD  = 8'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              level_out_q, level_out_d;
    logic              busy_q, busy_d;

    logic              pend_inc;
    logic              pend_dec;
    logic              drop;

    // Next-state logic: window/gap sequencing and the pending queue.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_inc = 1'b0;
        pend_dec = 1'b0;

        case (state_q)
            IDLE: begin
                // A pulse in IDLE starts a window directly and never touches
                // the queue.
                if (pulseIn) begin
                    state_d = HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end

            HIGH: begin
                pend_inc = pulseIn;
                if (cnt_q == 8'd0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            GAP: begin
                if (cnt_q == 8'd0) begin
                    if (pending_q != '0) begin
                        // Start the next window from the queue. A pulse in
                        // this same cycle takes the freed slot, so the count
                        // stays where it was.
                        state_d  = HIGH;
                        cnt_d    = HIGH_LOAD;
                        pend_dec = 1'b1;
                        pend_inc = pulseIn;
                    end else if (pulseIn) begin
                        // With an empty queue, a pulse on the final gap cycle
                        // is consumed directly and never enters the queue.
                        state_d = HIGH;
                        cnt_d   = HIGH_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    pend_inc = pulseIn;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Saturating pending counter and sticky overflow flag.
    // A pulse is dropped only when the queue is full and no slot is freed in
    // the same cycle. A drop takes priority over clrOvf.
    always_comb begin
        drop      = pend_inc && !pend_dec && (pending_q == PEND_MAX);
        pending_d = pending_q;
        if (pend_inc && !pend_dec && !drop) begin
            pending_d = pending_q + PEND_ONE;
        end else if (pend_dec && !pend_inc) begin
            pending_d = pending_q - PEND_ONE;
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clrOvf) begin
            overflow_d = 1'b0;
        end

        level_out_d = (state_d == HIGH);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            level_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            level_out_q <= level_out_d;
            busy_q      <= busy_d;
        end
    end

    assign levelOut = level_out_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher
//
// Purpose:
//   Directed testbench for pulse_stretcher with the default parameters
//   (HIGH_CYCLES=8, GAP_CYCLES=4, PEND_W=3).
//
// Cycle numbering:
//   "Edge e" is the e-th rising clock edge of a scenario, counted from 0.
//   "Cycle c" is the clock period that follows edge c-1.
//   The outputs are sampled 1 time unit after each edge.

module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulseIn;
    logic       clrOvf;
    logic       levelOut;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    pulse_stretcher dut (
        .clk      (clk),
        .rst      (rst),
        .pulseIn  (pulseIn),
        .clrOvf   (clrOvf),
        .levelOut (levelOut),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    // Compares one observed value against an expected value.
    // Every check counts toward the totals; a mismatch prints a FAIL line.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives the inputs for one edge, waits for that edge, then returns
    // 1 time unit later. The inputs are back to 0 on return.
    task automatic applyStimulus(input logic p, input logic c);
        pulseIn = p;
        clrOvf  = c;
        @(posedge clk);
        #1;
        pulseIn = 1'b0;
        clrOvf  = 1'b0;
    endtask

    // Pulses reset low away from any clock edge and checks the cleared
    // outputs. It then releases reset and lets one idle edge pass.
    task automatic doReset(input string tag);
        pulseIn = 1'b0;
        clrOvf  = 1'b0;
        rst     = 1'b0;
        #7;
        checkOutput({tag, " rst levelOut"}, int'(levelOut), 0);
        checkOutput({tag, " rst busy"},     int'(busy),     0);
        checkOutput({tag, " rst pending"},  int'(pending),  0);
        checkOutput({tag, " rst overflow"}, int'(overflow), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Checks levelOut, busy and pending for one cycle.
    task automatic checkCycle(input string tag, input int c, input int expLevel,
                              input int expBusy, input int expPend);
        checkOutput($sformatf("%s levelOut c%0d", tag, c), int'(levelOut), expLevel);
        checkOutput($sformatf("%s busy c%0d", tag, c),     int'(busy),     expBusy);
        checkOutput($sformatf("%s pending c%0d", tag, c),  int'(pending),  expPend);
    endtask

    initial begin
        int c;
        int expLevel;
        int expPend;

        rst     = 1'b0;
        pulseIn = 1'b0;
        clrOvf  = 1'b0;

        // Single pulse at edge 0.
        // Window on cycles 1..8, gap on 9..12, idle from cycle 13.
        doReset("single");
        for (int e = 0; e <= 14; e++) begin
            applyStimulus(e == 0, 1'b0);
            c = e + 1;
            checkCycle("single", c, (c >= 1 && c <= 8) ? 1 : 0, (c <= 12) ? 1 : 0, 0);
        end

        // Pulses at edges 0, 1 and 2 (pulseIn held for 3 cycles).
        // Windows on cycles 1..8, 13..20 and 25..32; idle from cycle 37.
        doReset("triple");
        for (int e = 0; e <= 38; e++) begin
            applyStimulus(e <= 2, 1'b0);
            c = e + 1;
            expLevel = ((c >= 1 && c <= 8) || (c >= 13 && c <= 20) ||
                        (c >= 25 && c <= 32)) ? 1 : 0;
            if (e == 0)       expPend = 0;
            else if (e == 1)  expPend = 1;
            else if (e <= 11) expPend = 2;
            else if (e <= 23) expPend = 1;
            else              expPend = 0;
            checkCycle("triple", c, expLevel, (c <= 36) ? 1 : 0, expPend);
        end
        checkOutput("triple overflow", int'(overflow), 0);

        // Second pulse on the final gap cycle (edge 12).
        // The next window follows immediately, with no idle cycle between.
        doReset("gapedge");
        for (int e = 0; e <= 25; e++) begin
            applyStimulus(e == 0 || e == 12, 1'b0);
            c = e + 1;
            expLevel = ((c >= 1 && c <= 8) || (c >= 13 && c <= 20)) ? 1 : 0;
            checkCycle("gapedge", c, expLevel, (c <= 24) ? 1 : 0, 0);
        end

        // pulseIn held high on edges 0..9.
        // The queue saturates at 7 by edge 7; the drops at edges 8 and 9 set
        // overflow.
        doReset("sat");
        for (int e = 0; e <= 9; e++) begin
            applyStimulus(1'b1, 1'b0);
            if (e == 0)     expPend = 0;
            else if (e < 7) expPend = e;
            else            expPend = 7;
            checkOutput($sformatf("sat pending e%0d", e), int'(pending), expPend);
            checkOutput($sformatf("sat overflow e%0d", e), int'(overflow), (e >= 8) ? 1 : 0);
        end
        // Edge 10: clrOvf at a quiet edge clears the flag.
        applyStimulus(1'b0, 1'b1);
        checkOutput("sat clr quiet overflow", int'(overflow), 0);
        checkOutput("sat clr quiet pending",  int'(pending),  7);
        checkOutput("sat clr quiet levelOut", int'(levelOut), 0);
        // Edge 11: a drop in the same cycle as clrOvf wins.
        applyStimulus(1'b1, 1'b1);
        checkOutput("sat clr+drop overflow", int'(overflow), 1);
        checkOutput("sat clr+drop pending",  int'(pending),  7);
        // Edge 12: final gap edge. The queue is full, but it dequeues in this
        // cycle, so the pulse is accepted and the flag clears.
        applyStimulus(1'b1, 1'b1);
        checkOutput("sat dequeue overflow", int'(overflow), 0);
        checkOutput("sat dequeue pending",  int'(pending),  7);
        checkOutput("sat dequeue levelOut", int'(levelOut), 1);
        checkOutput("sat dequeue busy",     int'(busy),     1);

        // Reset asserted mid-window (cycle 4), with no clock edge.
        doReset("async");
        for (int e = 0; e <= 3; e++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("async pre levelOut", int'(levelOut), 1);
        checkOutput("async pre pending",  int'(pending),  3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async levelOut", int'(levelOut), 0);
        checkOutput("async busy",     int'(busy),     0);
        checkOutput("async pending",  int'(pending),  0);
        checkOutput("async overflow", int'(overflow), 0);
        #2;
        rst = 1'b1;
        // No partial window resumes after release.
        applyStimulus(1'b0, 1'b0);
        checkCycle("async idle", 0, 0, 0, 0);
        // A new pulse yields a full 8-cycle window.
        for (int e = 0; e <= 13; e++) begin
            applyStimulus(e == 0, 1'b0);
            c = e + 1;
            checkCycle("async new", c, (c >= 1 && c <= 8) ? 1 : 0, (c <= 12) ? 1 : 0, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
